// File: rtl/wb_mem_pkg.sv
// Shared widths, FSM state type and wait-counter width for the Wishbone memory slave.
package wb_mem_pkg;

    localparam int unsigned WB_AW  = 32;
    localparam int unsigned WB_DW  = 128;
    localparam int unsigned WB_SW  = 16;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone classic bus bundle between a master and wb_mem_slave.
interface wb_mem_slave_if
    import wb_mem_pkg::*;
();

    logic [WB_AW-1:0] i_wb_adr;
    logic [WB_SW-1:0] i_wb_sel;
    logic             i_wb_we;
    logic [WB_DW-1:0] i_wb_dat;
    logic [WB_DW-1:0] o_wb_dat;
    logic             i_wb_cyc;
    logic             i_wb_stb;
    logic             o_wb_ack;
    logic             o_wb_err;

    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

endinterface

// File: rtl/wb_mem_array.sv
// DEPTH x 128-bit single-port RAM: byte-enabled synchronous write, combinational read.
module wb_mem_array
    import wb_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_idx,
    input  logic [WB_SW-1:0] i_sel,
    input  logic [WB_DW-1:0] i_dat,
    output logic [WB_DW-1:0] o_dat
);

    logic [WB_DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < WB_SW; b++) begin
                if (i_sel[b]) begin
                    mem[i_idx][8*b +: 8] <= i_dat[8*b +: 8];
                end
            end
        end
    end

    assign o_dat = mem[i_idx];

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone memory slave: request latch, wait-state FSM and address decode.
// Define WB_MEM_SLAVE_ERR_EN to terminate out-of-range accesses with err instead of aliasing.
module wb_mem_slave
    import wb_mem_pkg::*;
#(
    parameter logic [WB_AW-1:0] BASE_ADR    = 32'h0000_0000,
    parameter int unsigned      DEPTH       = 256,
    parameter int unsigned      WAIT_STATES = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    wb_mem_slave_if.slave wb
);

    localparam int unsigned        IW      = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0]  WS      = WCNT_W'(WAIT_STATES);
    localparam logic [WB_AW-5:0]   DEPTH_W = (WB_AW-4)'(DEPTH);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] cnt, cnt_nxt;

    logic [WB_AW-1:0]  adr_q;
    logic [WB_SW-1:0]  sel_q;
    logic              we_q;
    logic [WB_DW-1:0]  dat_q;

    logic              req;
    logic [WB_AW-1:0]  rel_adr;
    logic [WB_AW-5:0]  offset;
    logic              in_range;
    logic              ok;
    logic              resp_live;
    logic              mem_we;
    logic [WB_DW-1:0]  rd_dat;

    assign req = wb.i_wb_cyc & wb.i_wb_stb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            adr_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                adr_q <= wb.i_wb_adr;
                sel_q <= wb.i_wb_sel;
                we_q  <= wb.i_wb_we;
                dat_q <= wb.i_wb_dat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = WS;
                    state_nxt = (WS == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!wb.i_wb_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == WCNT_W'(1)) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Offset wraps for addresses below BASE_ADR, which lands them out of range.
    assign rel_adr  = adr_q - BASE_ADR;
    assign offset   = rel_adr[WB_AW-1:4];
    assign in_range = (offset < DEPTH_W);

    // A dropped cyc in the RESP cycle suppresses both the termination and the write.
    assign resp_live = (state == RESP) && wb.i_wb_cyc;

`ifdef WB_MEM_SLAVE_ERR_EN
    assign ok          = in_range;
    assign wb.o_wb_err = resp_live & ~ok;
    logic unused_bits;
    assign unused_bits = ^rel_adr[3:0];
`else
    assign ok          = 1'b1;
    assign wb.o_wb_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{rel_adr[3:0], in_range};
`endif

    assign wb.o_wb_ack = resp_live & ok;
    assign mem_we      = resp_live & ok & we_q;
    assign wb.o_wb_dat = (resp_live && ok && !we_q) ? rd_dat : '0;

    wb_mem_array #(
        .DEPTH (DEPTH),
        .AW    (IW)
    ) u_array (
        .i_clk (i_clk),
        .i_we  (mem_we),
        .i_idx (offset[IW-1:0]),
        .i_sel (sel_q),
        .i_dat (dat_q),
        .o_dat (rd_dat)
    );

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: two instances (1 and 3 wait states), directed cases plus random traffic.
module tb_wb_mem_slave;
    import wb_mem_pkg::*;

    localparam int unsigned    DEPTH = 16;
    localparam logic [31:0]    BASE0 = 32'h0000_0000;
    localparam logic [31:0]    BASE1 = 32'h0000_1000;
`ifdef WB_MEM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n [2];
    logic         b_cyc [2];
    logic         b_stb [2];
    logic         b_we  [2];
    logic [31:0]  b_adr [2];
    logic [15:0]  b_sel [2];
    logic [127:0] b_dat [2];

    logic         exp_ack [2];
    logic         exp_err [2];
    logic [127:0] exp_dat [2];
    logic [127:0] mdl [2][DEPTH];

    int n_checks = 0;
    int n_err    = 0;

    wb_mem_slave_if if0 ();
    wb_mem_slave_if if1 ();

    assign if0.i_wb_cyc = b_cyc[0];
    assign if0.i_wb_stb = b_stb[0];
    assign if0.i_wb_we  = b_we[0];
    assign if0.i_wb_adr = b_adr[0];
    assign if0.i_wb_sel = b_sel[0];
    assign if0.i_wb_dat = b_dat[0];
    assign if1.i_wb_cyc = b_cyc[1];
    assign if1.i_wb_stb = b_stb[1];
    assign if1.i_wb_we  = b_we[1];
    assign if1.i_wb_adr = b_adr[1];
    assign if1.i_wb_sel = b_sel[1];
    assign if1.i_wb_dat = b_dat[1];

    wb_mem_slave #(.BASE_ADR(BASE0), .DEPTH(DEPTH), .WAIT_STATES(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .wb(if0)
    );
    wb_mem_slave #(.BASE_ADR(BASE1), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .wb(if1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ack0", {127'd0, if0.o_wb_ack}, {127'd0, exp_ack[0]});
        chk("err0", {127'd0, if0.o_wb_err}, {127'd0, exp_err[0]});
        chk("dat0", if0.o_wb_dat, exp_dat[0]);
        chk("ack1", {127'd0, if1.o_wb_ack}, {127'd0, exp_ack[1]});
        chk("err1", {127'd0, if1.o_wb_err}, {127'd0, exp_err[1]});
        chk("dat1", if1.o_wb_dat, exp_dat[1]);
    end

    function automatic int unsigned ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    task automatic clear_exp(input int d);
        exp_ack[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_dat[d] = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle (or ready for a back-to-back call).
    task automatic xfer(input int d, input bit we, input logic [31:0] adr, input logic [15:0] sel,
                        input logic [127:0] dat, input int abort_at, input int rst_at,
                        output logic [127:0] rdat, output int lat,
                        output bit got_ack, output bit got_err);
        int unsigned ws;
        logic [31:0] rel;
        logic [31:0] off;
        int unsigned idx;
        bit ok;
        bit killed;
        ws      = ws_of(d);
        rel     = adr - base_of(d);
        off     = rel >> 4;
        idx     = off % DEPTH;
        ok      = (off < DEPTH) || !ERR_EN;
        killed  = 1'b0;
        rdat    = '0;
        lat     = -1;
        got_ack = 1'b0;
        got_err = 1'b0;
        b_cyc[d] = 1'b1; b_stb[d] = 1'b1; b_we[d] = we;
        b_adr[d] = adr;  b_sel[d] = sel;  b_dat[d] = dat;
        clear_exp(d);
        for (int j = 0; j <= int'(ws); j++) begin
            @(posedge clk); #1;
            if (j == abort_at) begin
                b_cyc[d] = 1'b0; b_stb[d] = 1'b0;
                killed = 1'b1;
                clear_exp(d);
            end else if (j == rst_at) begin
                rst_n[d] = 1'b0;
                killed = 1'b1;
                clear_exp(d);
            end else if (j == int'(ws)) begin
                exp_ack[d] = ok;
                exp_err[d] = !ok;
                exp_dat[d] = (ok && !we) ? mdl[d][idx] : '0;
            end
            if (killed) break;
            if (((d == 0) ? if0.o_wb_ack : if1.o_wb_ack) && lat < 0) lat = j + 1;
            if (j == int'(ws)) begin
                rdat    = (d == 0) ? if0.o_wb_dat : if1.o_wb_dat;
                got_ack = (d == 0) ? if0.o_wb_ack : if1.o_wb_ack;
                got_err = (d == 0) ? if0.o_wb_err : if1.o_wb_err;
            end
        end
        @(posedge clk); #1;
        if (!killed && ok && we) begin
            for (int b = 0; b < 16; b++) begin
                if (sel[b]) mdl[d][idx][8*b +: 8] = dat[8*b +: 8];
            end
        end
        rst_n[d] = 1'b1;
        b_cyc[d] = 1'b0; b_stb[d] = 1'b0;
        clear_exp(d);
    endtask

    localparam logic [127:0] PAT_A = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] PAT_W0 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] PAT_P = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
    localparam logic [127:0] PAT_Q = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

    initial begin
        logic [127:0] rd;
        int           lat;
        bit           ga, ge;
        logic [127:0] pat;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; b_cyc[d] = 1'b0; b_stb[d] = 1'b0; b_we[d] = 1'b0;
            b_adr[d] = '0;   b_sel[d] = '0;   b_dat[d] = '0;
            clear_exp(d);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Fill both memories so every later read has defined contents.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                pat = {$urandom, $urandom, $urandom, $urandom};
                xfer(d, 1'b1, base_of(d) + 32'(w * 16), 16'hFFFF, pat, -1, -1, rd, lat, ga, ge);
            end
        end

        xfer(0, 1'b1, 32'h10, 16'hFFFF, PAT_A, -1, -1, rd, lat, ga, ge);
        chk("wr_lat", 128'(lat), 128'd2);
        chk("model_w1", mdl[0][1], PAT_A);
        xfer(0, 1'b0, 32'h10, 16'h0000, '0, -1, -1, rd, lat, ga, ge);
        chk("rd_lat", 128'(lat), 128'd2);
        chk("rd_dat", rd, PAT_A);

        xfer(0, 1'b1, 32'h30, 16'hFFFF, {16{8'h55}}, -1, -1, rd, lat, ga, ge);
        xfer(0, 1'b1, 32'h30, 16'h0001, 128'hAA, -1, -1, rd, lat, ga, ge);
        xfer(0, 1'b0, 32'h30, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("sel_dat", rd, {{15{8'h55}}, 8'hAA});

        xfer(0, 1'b1, 32'h40, 16'h0000, PAT_Q, -1, -1, rd, lat, ga, ge);
        xfer(0, 1'b0, 32'h40, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("sel0_ack", {127'd0, ga}, 128'd1);
        chk("sel0_dat", rd, mdl[0][4]);

        xfer(1, 1'b1, BASE1 + 32'h40, 16'hFFFF, PAT_P, -1, -1, rd, lat, ga, ge);
        xfer(1, 1'b0, BASE1 + 32'h40, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("ws3_lat", 128'(lat), 128'd4);
        chk("ws3_dat", rd, PAT_P);

        xfer(0, 1'b1, 32'h0, 16'hFFFF, PAT_W0, -1, -1, rd, lat, ga, ge);
        xfer(0, 1'b0, 32'(DEPTH * 16), 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("oor_err", {127'd0, ge}, ERR_EN ? 128'd1 : 128'd0);
        chk("oor_ack", {127'd0, ga}, ERR_EN ? 128'd0 : 128'd1);
        chk("oor_dat", rd, ERR_EN ? 128'd0 : PAT_W0);

        xfer(0, 1'b1, 32'h20, 16'hFFFF, PAT_P, -1, -1, rd, lat, ga, ge);
        xfer(0, 1'b1, 32'h20, 16'hFFFF, PAT_Q, 0, -1, rd, lat, ga, ge);
        chk("abort_noack", 128'(lat), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        xfer(0, 1'b0, 32'h20, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("abort_dat", rd, PAT_P);

        xfer(0, 1'b1, 32'h20, 16'hFFFF, PAT_Q, -1, 0, rd, lat, ga, ge);
        xfer(0, 1'b0, 32'h20, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("rst_lat", 128'(lat), 128'd2);
        chk("rst_dat", rd, PAT_P);

        // stb without cyc must never start a transfer; the compare process watches the outputs.
        b_stb[0] = 1'b1; b_we[0] = 1'b1; b_adr[0] = 32'h20; b_sel[0] = 16'hFFFF; b_dat[0] = PAT_Q;
        repeat (4) @(posedge clk);
        #1;
        b_stb[0] = 1'b0;
        xfer(0, 1'b0, 32'h20, 16'hFFFF, '0, -1, -1, rd, lat, ga, ge);
        chk("stb_only_dat", rd, PAT_P);

        for (int n = 0; n < 400; n++) begin
            int d;
            int ab, rs;
            logic [31:0] adr;
            d   = int'($urandom_range(0, 1));
            adr = ($urandom_range(0, 15) == 0) ? $urandom
                                               : base_of(d) + $urandom_range(0, 2 * DEPTH * 16 - 1);
            ab = -1;
            rs = -1;
            if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(0, ws_of(d)));
            else if ($urandom_range(0, 19) == 0) rs = int'($urandom_range(0, ws_of(d) - 1));
            xfer(d, 1'($urandom_range(0, 1)), adr, 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 ab, rs, rd, lat, ga, ge);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 Parameter BASE_ADR, default 32'h0000_0000: byte base address of the decoded window; 16-byte aligned.
REQ-002 Parameter DEPTH, default 256: number of 128-bit words; power of two, 2..4096.
REQ-003 Parameter WAIT_STATES, default 1: extra cycles inserted before the response; range 0..15.
REQ-004 Port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port i_wb_adr, input, 32: byte address from the Wishbone master.
REQ-007 Port i_wb_sel, input, 16: byte enables; bit n qualifies byte lane [8n+7:8n].
REQ-008 Port i_wb_we, input, 1: 1 = write, 0 = read.
REQ-009 Port i_wb_dat, input, 128: write data.
REQ-010 Port o_wb_dat, output, 128: read data.
REQ-011 Port i_wb_cyc, input, 1: bus cycle valid.
REQ-012 Port i_wb_stb, input, 1: transfer strobe.
REQ-013 Port o_wb_ack, output, 1: normal termination.
REQ-014 Port o_wb_err, output, 1: error termination.

Function
REQ-015 FSM states are IDLE, WAIT and RESP.
REQ-016 In IDLE, cyc&stb sampled high: latch adr, sel, we and dat; load wait counter with WAIT_STATES; go to WAIT, or to RESP if WAIT_STATES = 0.
REQ-017 In WAIT: counter decrements each cycle; on reaching 0, go to RESP.
REQ-018 In RESP: exactly one of ack or err is high for exactly one cycle; next state is IDLE.
REQ-019 Response latency is 1+WAIT_STATES cycles after the request edge; default latency is 2.
REQ-020 Address handling: word index = latched adr[3:0] discarded, offset (adr-BASE_ADR)>>4; offset < DEPTH means in range.
REQ-021 In-range write: bytes whose sel bit is 1 are updated at the RESP edge; other bytes are unchanged; sel = 0 still acks with no change.
REQ-022 In-range read: o_wb_dat carries the full 128-bit word during the RESP cycle, regardless of sel; o_wb_dat is 0 in every other cycle.
REQ-023 Abort: i_wb_cyc low in WAIT or RESP returns the FSM to IDLE next cycle, with no ack, no err and no memory write.
REQ-024 A request still asserted in the cycle after RESP is accepted as a new transfer from IDLE; there is no dead cycle beyond the IDLE sample.
REQ-025 i_wb_stb with i_wb_cyc low is ignored.
REQ-026 Write-then-read to the same word returns the newly written data.

Reset
REQ-027 While i_rst_n is low: FSM = IDLE, counter = 0, o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0, latched request cleared.
REQ-028 Reset asserted mid-transfer abandons the transfer: no response and no write.
REQ-029 Memory contents are not reset; reads before any write return undefined data.

Configuration
REQ-030 With macro WB_MEM_SLAVE_ERR_EN defined, an out-of-range access terminates with o_wb_err, performs no write, and drives read data 0.
REQ-031 Without WB_MEM_SLAVE_ERR_EN, out-of-range accesses alias to offset modulo DEPTH, complete with ack, and o_wb_err is tied 0.

Structure
REQ-032 Package wb_mem_pkg holds:
- WB_AW = 32, WB_DW = 128, WB_SW = 16
- the FSM state enum
- the wait-counter width constant
REQ-033 Sub-module wb_mem_array implements the DEPTH x 128 byte-enabled single-port RAM (synchronous write, combinational or registered read aligned to RESP); wb_mem_slave holds the FSM and address decode.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Write adr 0x10, sel 0xFFFF, dat 0x0123..CDEF, then read adr 0x10 -> ack at cycle 2 after each request; read data 0x0123..CDEF.
- Write sel 0x0001, dat 0xAA to a word holding all 0x55 bytes, then read -> word 0x5555...55AA.
- WAIT_STATES = 3, single read -> ack exactly 4 cycles after request; ack width 1; o_wb_dat 0 outside the ack cycle.
- With ERR_EN, read adr BASE_ADR+DEPTH*16 -> err for 1 cycle, ack 0, data 0. Without ERR_EN, same access -> ack, data of word 0.
- Drop cyc in the WAIT cycle of a write to 0x20 -> no ack/err; a subsequent read of 0x20 returns the prior contents.
- Assert i_rst_n low during WAIT -> ack/err/dat 0 immediately; FSM IDLE; next request serviced normally.
